// File: rtl/bh_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bh_tx_arbiter
// Brief   : Round-robin share of one uart_send between a buffered echo path
//           (port A) and a valid/ready byte source (port B).
// Rev     : 1.0  initial release
// ============================================================================
module bh_tx_arbiter #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 9600,
  parameter int FRAME_BITS = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       key_ready,
  output logic       uart_en,
  output logic [7:0] uart_din,
  output logic       tx_busy,
  output logic       rx_overflow,
  output logic [7:0] drop_cnt
);

  localparam int c_frame_cyc = (CLK_FREQ / UART_BPS) * FRAME_BITS;
  localparam int c_cnt_w     = (c_frame_cyc > 1) ? $clog2(c_frame_cyc + 1) : 1;
  localparam int c_ptr_w     = $clog2(FIFO_DEPTH);
  localparam int c_fcnt_w    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_frame_cnt;
  logic                 w_frame_done;
  logic                 r_last_grant_b;
  logic                 w_req_a;
  logic                 w_req_b;
  logic                 w_grant_a;
  logic                 w_grant_b;
  logic [7:0]           r_uart_din;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_fcnt_w-1:0]  r_fifo_cnt;
  logic                 w_fifo_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic [7:0]           w_fifo_head;
  logic                 r_rx_overflow;
  logic [7:0]           r_drop_cnt;

  // --------------------------------------------------------------------------
  // Arbitration and sequencing
  // --------------------------------------------------------------------------
  assign w_req_a      = (r_fifo_cnt != '0);
  assign w_req_b      = key_valid;
  assign w_frame_done = (r_state == ST_WAIT) &&
                        (r_frame_cnt == c_cnt_w'(c_frame_cyc - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // On a tie the port that did not win last time is granted.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_a && (!w_req_b || r_last_grant_b)) begin
          w_grant_a   = 1'b1;
          w_state_nxt = ST_LAUNCH;
        end else if (w_req_b) begin
          w_grant_b   = 1'b1;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_frame_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // uart_send has no busy flag, so a whole frame time is waited out.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame_cnt <= '0;
    end else if (r_state == ST_LAUNCH) begin
      r_frame_cnt <= '0;
    end else if (r_state == ST_WAIT && !w_frame_done) begin
      r_frame_cnt <= r_frame_cnt + c_cnt_w'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_uart_din     <= 8'h00;
      r_last_grant_b <= 1'b1;
    end else if (w_grant_a) begin
      r_uart_din     <= w_fifo_head;
      r_last_grant_b <= 1'b0;
    end else if (w_grant_b) begin
      r_uart_din     <= key_data;
      r_last_grant_b <= 1'b1;
    end
  end

  assign key_ready = w_grant_b;
  assign uart_en   = (r_state == ST_LAUNCH);
  assign tx_busy   = (r_state != ST_IDLE);
  assign uart_din  = r_uart_din;

  // --------------------------------------------------------------------------
  // Echo FIFO (pop-then-push: a full FIFO still accepts when popped this cycle)
  // --------------------------------------------------------------------------
  assign w_fifo_full = (r_fifo_cnt == c_fcnt_w'(FIFO_DEPTH));
  assign w_pop       = w_grant_a;
  assign w_push      = rx_done && (!w_fifo_full || w_pop);
  assign w_drop      = rx_done && !w_push;
  assign w_fifo_head = r_mem[r_rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + c_fcnt_w'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - c_fcnt_w'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_overflow <= 1'b0;
      r_drop_cnt    <= 8'h00;
    end else begin
      r_rx_overflow <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'h01;
      end
    end
  end

  assign rx_overflow = r_rx_overflow;
  assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bh_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bh_tx_arbiter
// Brief   : Scoreboard bench for bh_tx_arbiter (FRAME_CYC = 100, depth 4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_bh_tx_arbiter;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_ready;
  logic       uart_en;
  logic [7:0] uart_din;
  logic       tx_busy;
  logic       rx_overflow;
  logic [7:0] drop_cnt;

  bh_tx_arbiter #(
    .CLK_FREQ   (1000),
    .UART_BPS   (100),
    .FRAME_BITS (10),
    .FIFO_DEPTH (4)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (sys_rst_n),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .key_valid   (key_valid),
    .key_data    (key_data),
    .key_ready   (key_ready),
    .uart_en     (uart_en),
    .uart_din    (uart_din),
    .tx_busy     (tx_busy),
    .rx_overflow (rx_overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;   // absolute launch cycle, -1 = unchecked
    int         gap;   // cycles since previous launch, -1 = unchecked
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_launch = 0;
  int   launch_cnt = 0;
  int   busy_cnt = 0;
  int   kr_cnt = 0;
  int   ovf_cnt = 0;
  bit   sb_bypass = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every launch pulse.
  always @(negedge clk) begin
    if (sys_rst_n) begin
      if (tx_busy) busy_cnt++;
      if (key_ready) kr_cnt++;
      if (rx_overflow) ovf_cnt++;
      if (uart_en) begin
        exp_t e;
        launch_cnt++;
        if (!sb_bypass) begin
          if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_launch: actual 0x%0h, expected none (cycle %0d)", uart_din, cyc);
          end else begin
            e = sbq.pop_front();
            check("launch_data", uart_din, e.data);
            if (e.cyc >= 0) check("launch_cycle", cyc, e.cyc);
            if (e.gap >= 0) check("launch_gap", cyc - last_launch, e.gap);
          end
        end
        last_launch = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input int c, input int g);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    e.gap  = g;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    rx_done   = 1'b0;
    key_valid = 1'b0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic push_rx(input logic [7:0] d);
    rx_done = 1'b1;
    rx_data = d;
    tick();
    rx_done = 1'b0;
  endtask

  // Returns one cycle after the grant edge, i.e. in the LAUNCH cycle.
  task automatic key_wait_accept();
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (key_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("key_accept_seen", int'(got), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic key_send(input logic [7:0] d);
    key_valid = 1'b1;
    key_data  = d;
    key_wait_accept();
    key_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (sbq.size() == 0 && !tx_busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("drain_done", int'(done), 1);
    repeat (3) tick();
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) tick();
  endtask

  initial begin
    int n;
    int l;
    int snap;
    sys_rst_n = 1'b1;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    key_valid = 1'b0;
    key_data  = 8'h00;

    // Reset values
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_uart_en", uart_en, 0);
    check("rst_uart_din", uart_din, 0);
    check("rst_key_ready", key_ready, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_overflow", rx_overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();

    // 1: single echo byte
    busy_cnt = 0;
    kr_cnt   = 0;
    expect_byte(8'h41, cyc + 2, -1);
    push_rx(8'h41);
    wait_drain();
    check("t1_busy_cycles", busy_cnt, 101);
    check("t1_key_ready_cnt", kr_cnt, 0);

    // 2: tie after reset goes to A, then B 102 cycles later
    do_reset();
    kr_cnt = 0;
    expect_byte(8'h31, cyc + 2, -1);
    expect_byte(8'h55, -1, 102);
    rx_done = 1'b1;
    rx_data = 8'h31;
    tick();
    rx_done   = 1'b0;
    key_valid = 1'b1;
    key_data  = 8'h55;
    key_wait_accept();
    key_valid = 1'b0;
    wait_drain();
    check("t2_key_ready_cnt", kr_cnt, 1);

    // 3: sustained traffic on both ports alternates A,B,A,B,A,B
    do_reset();
    kr_cnt = 0;
    expect_byte(8'hA1, cyc + 2, -1);
    expect_byte(8'hB1, -1, 102);
    expect_byte(8'hA2, -1, 102);
    expect_byte(8'hB2, -1, 102);
    expect_byte(8'hA3, -1, 102);
    expect_byte(8'hB3, -1, 102);
    rx_done = 1'b1;
    rx_data = 8'hA1;
    tick();
    rx_data   = 8'hA2;
    key_valid = 1'b1;
    key_data  = 8'hB1;
    tick();
    rx_data = 8'hA3;
    tick();
    rx_done = 1'b0;
    key_wait_accept();
    key_data = 8'hB2;
    key_wait_accept();
    key_data = 8'hB3;
    key_wait_accept();
    key_valid = 1'b0;
    wait_drain();
    check("t3_key_ready_cnt", kr_cnt, 3);

    // 4: six pushes during WAIT overflow a depth-4 FIFO by two
    do_reset();
    ovf_cnt = 0;
    expect_byte(8'h77, cyc + 1, -1);
    for (int i = 1; i <= 4; i++) expect_byte(8'(i), -1, 102);
    key_send(8'h77);
    repeat (10) tick();
    for (int i = 1; i <= 6; i++) push_rx(8'(i));
    repeat (2) tick();
    check("t4_overflow_pulses", ovf_cnt, 2);
    check("t4_drop_cnt", drop_cnt, 2);
    wait_drain();

    // 5: push into a full FIFO in the same cycle as an A grant
    do_reset();
    ovf_cnt = 0;
    expect_byte(8'h88, cyc + 1, -1);
    for (int i = 0; i < 5; i++) expect_byte(8'h11 + 8'(i), -1, 102);
    key_send(8'h88);
    l = cyc;
    for (int i = 0; i < 4; i++) push_rx(8'h11 + 8'(i));
    check("t5_fifo_full", int'(dut.r_fifo_cnt), 4);
    wait_cyc(l + 101);
    push_rx(8'h15);
    check("t5_fifo_cnt_after", int'(dut.r_fifo_cnt), 4);
    tick();
    check("t5_overflow_pulses", ovf_cnt, 0);
    check("t5_drop_cnt", drop_cnt, 0);
    wait_drain();

    // 6: reset in the middle of WAIT with three bytes queued
    do_reset();
    expect_byte(8'h99, cyc + 1, -1);
    key_send(8'h99);
    l = cyc;
    push_rx(8'h21);
    push_rx(8'h22);
    push_rx(8'h23);
    wait_cyc(l + 50);
    check("t6_busy_before", tx_busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_uart_en", uart_en, 0);
    check("t6_rst_uart_din", uart_din, 0);
    check("t6_rst_tx_busy", tx_busy, 0);
    check("t6_rst_key_ready", key_ready, 0);
    check("t6_rst_drop_cnt", drop_cnt, 0);
    @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    snap = launch_cnt;
    repeat (300) tick();
    check("t6_no_launch", launch_cnt - snap, 0);
    expect_byte(8'h42, cyc + 2, -1);
    push_rx(8'h42);
    wait_drain();

    // drop_cnt saturation: over 300 drops with the FIFO kept full
    do_reset();
    sb_bypass = 1'b1;
    rx_done   = 1'b1;
    rx_data   = 8'hEE;
    repeat (310) tick();
    rx_done = 1'b0;
    tick();
    check("sat_drop_cnt", drop_cnt, 255);
    do_reset();
    sb_bypass = 1'b0;
    check("sat_rst_drop_cnt", drop_cnt, 0);

    check("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
